// File: rtl/ms_timer_pkg.sv
// ms_timer_pkg
//   Shared definitions for the millisecond timer bank: channel state
//   encoding and the default counter width / reset terminal count.
//   No ports.
package ms_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CW_DEF         = 24;
  localparam int DEFAULT_TC_DEF = 800000;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int sel_width(input int nch);
    sel_width = (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/ms_timer_channel.sv
// ms_timer_channel
//   One timer channel: IDLE/RUN state, counter, active and shadow terminal
//   count, latched mode and the registered timeout pulse / busy flag.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset
//     tick              counter enable (constant 1 without a prescaler)
//     start, stop       start/retrigger and abort (stop has priority)
//     periodic          mode sampled at start: 1 = auto-reload
//     tc_we, tc_value   shadow terminal-count write (already decoded)
//     timeout, busy     one-cycle expiry pulse, running flag
module ms_timer_channel
  import ms_timer_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int DEFAULT_TC = DEFAULT_TC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic          tc_we,
  input  logic [CW-1:0] tc_value,
  output logic          timeout,
  output logic          busy
);

  state_t        state_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] tc_r;
  logic [CW-1:0] shadow_r;
  logic          mode_r;
  logic          timeout_r;
  logic          busy_r;
  logic [CW-1:0] last_s;
  logic          expire_s;

  // A terminal count of 0 behaves as 1, so the final count value is 0 too.
  assign last_s   = (tc_r == {CW{1'b0}}) ? {CW{1'b0}} : (tc_r - CW'(1'b1));
  assign expire_s = (state_r == ST_RUN) && tick && (count_r == last_s);

  // Shadow terminal count: written any cycle, consumed only at start/reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r <= CW'(DEFAULT_TC);
    end else if (tc_we) begin
      shadow_r <= tc_value;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Channel FSM with counter; priority is stop > start > expiry > count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      tc_r      <= CW'(DEFAULT_TC);
      mode_r    <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (stop) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (start) begin
      // A retrigger landing on the expiry edge still reports that expiry.
      state_r   <= ST_RUN;
      count_r   <= {CW{1'b0}};
      tc_r      <= shadow_r;
      mode_r    <= periodic;
      timeout_r <= expire_s;
      busy_r    <= 1'b1;
    end else if (expire_s) begin
      timeout_r <= 1'b1;
      count_r   <= {CW{1'b0}};
      if (mode_r) begin
        tc_r <= shadow_r;
      end else begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end
    end else begin
      timeout_r <= 1'b0;
      if ((state_r == ST_RUN) && tick) begin
        count_r <= count_r + CW'(1'b1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign timeout = timeout_r;
  assign busy    = busy_r;

endmodule

// File: rtl/ms_timer_bank.sv
// ms_timer_bank
//   NCH independent millisecond timer channels with per-channel terminal
//   count, one-shot/periodic mode and a one-cycle timeout pulse.
//   Optional macro MS_TIMER_PRESCALE_EN adds a shared prescaler (parameter
//   PRESCALE, present only in that build) so channels advance once every
//   PRESCALE clocks; otherwise channels advance every clock.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     start[NCH]     per-channel start/retrigger (level)
//     stop[NCH]      per-channel abort
//     periodic[NCH]  per-channel mode sampled at start
//     tc_we, tc_sel, tc_value  terminal-count shadow write; tc_sel >= NCH ignored
//     timeout[NCH]   one-cycle expiry pulse
//     busy[NCH]      channel running
module ms_timer_bank
  import ms_timer_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int NCH        = 2,
  parameter int DEFAULT_TC = DEFAULT_TC_DEF
`ifdef MS_TIMER_PRESCALE_EN
  ,
  parameter int PRESCALE   = 1000
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NCH-1:0]            start,
  input  logic [NCH-1:0]            stop,
  input  logic [NCH-1:0]            periodic,
  input  logic                      tc_we,
  input  logic [sel_width(NCH)-1:0] tc_sel,
  input  logic [CW-1:0]             tc_value,
  output logic [NCH-1:0]            timeout,
  output logic [NCH-1:0]            busy
);

  localparam int SELW = sel_width(NCH);

  logic           tick_s;
  logic [NCH-1:0] tc_we_s;

`ifdef MS_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt_r;

  assign tick_s = (pre_cnt_r == PW'(PRESCALE - 1));

  // Free-running prescaler, wraps at PRESCALE-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= {PW{1'b0}};
    end else if (tick_s) begin
      pre_cnt_r <= {PW{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1'b1);
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Channel-select decode; out-of-range indices match no channel.
  always_comb begin
    tc_we_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      tc_we_s[i] = tc_we && (tc_sel == SELW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ms_timer_channel #(
      .CW         (CW),
      .DEFAULT_TC (DEFAULT_TC)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick_s),
      .start    (start[g]),
      .stop     (stop[g]),
      .periodic (periodic[g]),
      .tc_we    (tc_we_s[g]),
      .tc_value (tc_value),
      .timeout  (timeout[g]),
      .busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_ms_timer_bank.sv
// tb_ms_timer_bank
//   Directed bench for ms_timer_bank (default build, NCH=2). DEFAULT_TC is
//   overridden to 20 so the reset terminal count can be observed quickly.
//   Edge 0 is the clock edge at which start is sampled; outputs are
//   sampled 1 time unit after each edge.
module tb_ms_timer_bank;

  localparam int CW  = 24;
  localparam int NCH = 2;
  localparam int DTC = 20;

  logic           clk;
  logic           reset_n;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] periodic;
  logic           tc_we;
  logic [0:0]     tc_sel;
  logic [CW-1:0]  tc_value;
  logic [NCH-1:0] timeout;
  logic [NCH-1:0] busy;

  int total;
  int bad;

  ms_timer_bank #(
    .CW         (CW),
    .NCH        (NCH),
    .DEFAULT_TC (DTC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .tc_we    (tc_we),
    .tc_sel   (tc_sel),
    .tc_value (tc_value),
    .timeout  (timeout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tc(input int sel, input int val);
    tc_we    = 1'b1;
    tc_sel   = sel[0:0];
    tc_value = val[CW-1:0];
    step();
    tc_we    = 1'b0;
  endtask

  task automatic go(input int ch, input logic per);
    start[ch]    = 1'b1;
    periodic[ch] = per;
    step();
    start[ch]    = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    start    = 2'b00;
    stop     = 2'b00;
    periodic = 2'b00;
    tc_we    = 1'b0;
    tc_sel   = 1'b0;
    tc_value = 24'd0;
    #1;
    check("rst timeout", 32'(timeout), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    #20;
    reset_n = 1'b1;
    step();

    // One-shot, tc=5: pulse after edge 5 only, busy over edges 0..4.
    wr_tc(0, 5);
    go(0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("oneshot to k=%0d", k), 32'(timeout[0]), 32'(k == 5));
      check($sformatf("oneshot busy k=%0d", k), 32'(busy[0]), 32'(k < 5));
    end

    // Periodic ch1, tc=3: pulses after 3, 6, 9; stop at edge 10.
    wr_tc(1, 3);
    go(1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      if (k == 10) stop[1] = 1'b1;
      step();
      stop[1] = 1'b0;
      check($sformatf("per to k=%0d", k), 32'(timeout[1]), 32'((k == 3) || (k == 6) || (k == 9)));
      check($sformatf("per busy k=%0d", k), 32'(busy[1]), 32'(k < 10));
      check($sformatf("per ch0 quiet k=%0d", k), 32'(timeout[0]), 32'd0);
    end

    // Retrigger ch0, tc=10: restart at edge 7, single pulse after edge 17.
    wr_tc(0, 10);
    go(0, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      start[0] = (k == 7);
      step();
      start[0] = 1'b0;
      check($sformatf("retrig to k=%0d", k), 32'(timeout[0]), 32'(k == 17));
      check($sformatf("retrig busy k=%0d", k), 32'(busy[0]), 32'(k < 17));
    end

    // Stop on the expiry edge, tc=4: no pulse, idle.
    wr_tc(0, 4);
    go(0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) stop[0] = 1'b1;
      step();
      stop[0] = 1'b0;
      check($sformatf("stopexp to k=%0d", k), 32'(timeout[0]), 32'd0);
      check($sformatf("stopexp busy k=%0d", k), 32'(busy[0]), 32'(k < 4));
    end

    // Stop and start together: stays idle.
    stop[0]  = 1'b1;
    start[0] = 1'b1;
    step();
    stop[0]  = 1'b0;
    start[0] = 1'b0;
    check("stop+start busy", 32'(busy[0]), 32'd0);
    step();
    check("stop+start busy later", 32'(busy[0]), 32'd0);

    // Shadow write during a run does not change the current period.
    wr_tc(0, 8);
    go(0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        tc_we    = 1'b1;
        tc_sel   = 1'b0;
        tc_value = 24'd2;
      end
      step();
      tc_we = 1'b0;
      check($sformatf("shadow to k=%0d", k), 32'(timeout[0]), 32'(k == 8));
    end
    go(0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("tc2 to k=%0d", k), 32'(timeout[0]), 32'(k == 2));
    end
    wr_tc(0, 0);
    go(0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      step();
      check($sformatf("tc0 to k=%0d", k), 32'(timeout[0]), 32'(k == 1));
      check($sformatf("tc0 busy k=%0d", k), 32'(busy[0]), 32'd0);
    end

    // Asynchronous reset while a pulse is high and ch1 is running.
    wr_tc(0, 2);
    wr_tc(1, 3);
    start    = 2'b11;
    periodic = 2'b10;
    step();
    start    = 2'b00;
    step();
    step();
    check("pre-rst to0", 32'(timeout[0]), 32'd1);
    check("pre-rst busy", 32'(busy), 32'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst timeout", 32'(timeout), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    #3;
    reset_n = 1'b1;
    step();
    check("post-rst busy", 32'(busy), 32'd0);
    go(0, 1'b0);
    for (int k = 1; k <= DTC + 1; k++) begin
      step();
      check($sformatf("dflt to k=%0d", k), 32'(timeout[0]), 32'(k == DTC));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
